// File: rtl/pingpong_feeder.sv
// Two-entry ping-pong buffer feeding a 2:1 selector (route_0/route_1/sel).
// Optional simulation trace of writes, reads and stalls: define PINGPONG_FEEDER_DEBUG_EN.
module pingpong_feeder #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                in_ready,
  output logic [BITWIDTH-1:0] route_0,
  output logic [BITWIDTH-1:0] route_1,
  output logic                sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [BITWIDTH-1:0] bank0;
  logic [BITWIDTH-1:0] bank1;
  logic                full0;
  logic                full1;
  logic                wr_ptr;
  logic                wr_acc;
  logic                rd_acc;

  // Handshake status depends only on registered flags, never on in_valid/out_ready.
  assign in_ready  = wr_ptr ? !full1 : !full0;
  assign out_valid = sel ? full1 : full0;
  assign wr_acc    = in_valid && in_ready;
  assign rd_acc    = out_valid && out_ready;

  assign route_0 = bank0;
  assign route_1 = bank1;
  assign level   = state;

  // Bank storage, full flags and pointers; a read never clears bank data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0  <= '0;
      bank1  <= '0;
      full0  <= 1'b0;
      full1  <= 1'b0;
      wr_ptr <= 1'b0;
      sel    <= 1'b0;
    end else begin
      if (wr_acc) begin
        if (wr_ptr) begin
          bank1 <= in_data;
          full1 <= 1'b1;
        end else begin
          bank0 <= in_data;
          full0 <= 1'b1;
        end
        wr_ptr <= !wr_ptr;
      end
      // Simultaneous write and read always target opposite banks.
      if (rd_acc) begin
        if (sel) full1 <= 1'b0;
        else     full0 <= 1'b0;
        sel <= !sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Occupancy state tracks full0 + full1.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (wr_acc) state_nxt = HALF;
      HALF: begin
        if (wr_acc && !rd_acc)      state_nxt = FULL;
        else if (rd_acc && !wr_acc) state_nxt = EMPTY;
      end
      FULL:    if (rd_acc) state_nxt = HALF;
      default: state_nxt = EMPTY;
    endcase
  end

`ifdef PINGPONG_FEEDER_DEBUG_EN
  logic stall_seen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_seen <= 1'b0;
    end else begin
      if (wr_acc) $display("W bank:%b data:%b level:%d", wr_ptr, in_data, level);
      if (rd_acc) $display("R bank:%b data:%b level:%d", sel, sel ? bank1 : bank0, level);
      if (in_valid && state == FULL) begin
        if (!stall_seen) $display("STALL");
        stall_seen <= 1'b1;
      end else begin
        stall_seen <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_feeder.sv
// Self-checking bench for pingpong_feeder: directed steps plus random traffic vs a queue model.
module tb_pingpong_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] route_0;
  logic [7:0] route_1;
  logic       sel;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] level;

  int checks = 0;
  int fails  = 0;

  // Model: FIFO of stored words; n-th written word lands in bank n%2, n-th read from bank n%2.
  logic [7:0] q[$];
  logic [7:0] mbank[2];
  int         wr_cnt;
  int         rd_cnt;

  pingpong_feeder #(.BITWIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .route_0   (route_0),
    .route_1   (route_1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  always #5 clk = !clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mbank[0] = 8'h00;
    mbank[1] = 8'h00;
    wr_cnt   = 0;
    rd_cnt   = 0;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] head;
    check({tag, ".route_0"},   32'(route_0),   32'(mbank[0]));
    check({tag, ".route_1"},   32'(route_1),   32'(mbank[1]));
    check({tag, ".sel"},       32'(sel),       32'(rd_cnt % 2));
    check({tag, ".level"},     32'(level),     32'(q.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
    if (q.size() > 0) begin
      head = (rd_cnt % 2 == 1) ? route_1 : route_0;
      check({tag, ".head"}, 32'(head), 32'(q[0]));
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare at next negedge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input string tag);
    bit wa;
    bit ra;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    wa = v && (q.size() < 2);
    ra = r && (q.size() > 0);
    @(posedge clk);
    if (ra) begin
      q.delete(0);
      rd_cnt++;
    end
    if (wa) begin
      mbank[wr_cnt % 2] = d;
      q.push_back(d);
      wr_cnt++;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset asserted mid low phase, checked before any clock edge.
  task automatic async_reset(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    check_all({tag, "_hold"});
    rst_n = 1'b1;
  endtask

  initial begin
    int target;
    int budget;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Single word, then one read.
    cycle(1'b1, 8'hA5, 1'b0, "single_wr");
    check("single_route0", 32'(route_0), 32'h0000_00A5);
    cycle(1'b0, 8'h00, 1'b0, "single_idle");
    cycle(1'b0, 8'h00, 1'b1, "single_rd");
    check("single_sel_after_rd", 32'(sel), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, "empty_rd_ignored");

    // Back to a known pointer state for the fill test.
    async_reset("reset_mid_clock");

    // Fill and stall.
    cycle(1'b1, 8'h11, 1'b0, "fill_a");
    cycle(1'b1, 8'h22, 1'b0, "fill_b");
    check("fill_level", 32'(level), 32'd2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h33, 1'b0, "stall");
    cycle(1'b1, 8'h33, 1'b1, "stall_rd");
    cycle(1'b1, 8'h33, 1'b0, "stall_accept");
    check("stall_bank0", 32'(route_0), 32'h0000_0033);
    cycle(1'b0, 8'h00, 1'b1, "drain_a");
    cycle(1'b0, 8'h00, 1'b1, "drain_b");
    check("drained_level", 32'(level), 32'd0);

    // Streaming: one word in and one out per cycle after the fill.
    for (int k = 1; k <= 10; k++) cycle(1'b1, 8'(k), 1'b1, "stream");
    check("stream_level", 32'(level), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, "stream_drain");

    // Random traffic: 200 more words through the model's order scoreboard.
    target = wr_cnt + 200;
    budget = 0;
    while (wr_cnt < target && budget < 5000) begin
      cycle(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), "rand");
      budget++;
    end
    check("rand_writes_done", 32'(wr_cnt >= target), 32'd1);
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      cycle(1'b0, 8'h00, 1'b1, "rand_drain");
      budget++;
    end
    check("rand_drained", 32'(q.size()), 32'd0);

    // Reset mid-operation with level 2.
    cycle(1'b1, 8'hC3, 1'b0, "pre_rst_a");
    cycle(1'b1, 8'h3C, 1'b0, "pre_rst_b");
    check("pre_rst_level", 32'(level), 32'd2);
    async_reset("reset_full");
    cycle(1'b1, 8'h5A, 1'b0, "post_rst_wr");
    check("post_rst_route0", 32'(route_0), 32'h0000_005A);
    check("post_rst_sel", 32'(sel), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/pingpong_feeder.md
Name: pingpong_feeder

Overview:
- Two-entry ping-pong buffer that sits directly upstream of the 2:1 N-bit selector.
- Accepts a valid/ready input stream and writes the words alternately into bank 0 and bank 1.
- Drives the selector's route_0 (bank 0), route_1 (bank 1) and sel (bank to read next). The selector output is the head word of the stream.
- Downstream acknowledges each consumed word with out_ready.

Parameters:
- BITWIDTH, 8, data width of in_data, route_0, route_1; must match the selector's BITWIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word available
- in_data  input  BITWIDTH  upstream word
- in_ready  output  1  buffer can accept in_data this cycle
- route_0  output  BITWIDTH  bank 0 contents, to selector route_0
- route_1  output  BITWIDTH  bank 1 contents, to selector route_1
- sel  output  1  read pointer, to selector sel (1 = bank 1)
- out_valid  output  1  word at selector output is valid
- out_ready  input  1  downstream consumes selected word this cycle
- level  output  2  occupancy, 0..2

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, takes effect immediately, no clock needed):
  - route_0 = 0, route_1 = 0, sel = 0.
  - Write pointer wr_ptr = 0, both full flags = 0, state = EMPTY.
  - Outputs: out_valid = 0, in_ready = 1, level = 0.
- Internal state:
  - bank0, bank1: BITWIDTH registers.
  - full0, full1: per-bank full flags.
  - wr_ptr: 1-bit write pointer.
  - sel: 1-bit read pointer.
- Combinational outputs:
  - in_ready = !full[wr_ptr]
  - out_valid = full[sel]
  - level = full0 + full1
- Write accept is in_valid && in_ready, on a rising edge:
  - bank[wr_ptr] <= in_data
  - full[wr_ptr] <= 1
  - wr_ptr toggles
- Read accept is out_valid && out_ready, on a rising edge:
  - full[sel] <= 0
  - sel toggles
  - Bank data is not cleared on read; route_x keeps its stale value.
- Latency:
  - A word accepted at edge N gives out_valid = 1 and the word on route_[bank] after edge N (1 cycle).
  - No combinational path from in_valid to out_valid, or from out_ready to in_ready.
- State machine, equivalent to the level encoding:
  - EMPTY (level 0): write -> HALF; read not possible.
  - HALF (level 1): write only -> FULL; read only -> EMPTY; write and read together -> HALF.
  - FULL (level 2): write not possible (in_ready = 0); read -> HALF.
- Simultaneous events: a write and a read in the same cycle always hit different banks. Same-bank conflict is impossible: write needs !full[wr_ptr], read needs full[sel], and wr_ptr == sel implies those flags are equal.
- Wrap-around: pointers are 1 bit and wrap 1 -> 0 naturally. Order is preserved: the n-th written word is the n-th read word.
- Full/empty boundaries:
  - in_valid while FULL is ignored; upstream must hold the word.
  - out_ready while EMPTY is ignored.
- Reset mid-operation: all buffered words are discarded, and state returns to the reset values above within the same cycle as the rst_n assertion.
- Deassertion of rst_n is synchronised externally. First accept is possible at the first rising edge with rst_n high.

Optional Feature:
- Macro: PINGPONG_FEEDER_DEBUG_EN.
- Defined: on every accepted write, simulation prints "W bank:%b data:%b level:%d" with the values before the edge; on every accepted read, it prints "R bank:%b data:%b level:%d". When in_valid is high while FULL, it prints "STALL" once per stall episode. Non-synthesizable display code only; RTL behaviour is identical.
- Undefined: no display code compiled; synthesizes cleanly.

Test Plan:
- Reset check: assert rst_n = 0 mid-clock -> immediately route_0 = route_1 = 0, sel = 0, out_valid = 0, in_ready = 1, level = 0.
- Single word: write 8'hA5, out_ready = 0 -> next cycle out_valid = 1, sel = 0, route_0 = A5, level = 1. Then out_ready = 1 for one cycle -> sel = 1, out_valid = 0, level = 0.
- Fill and stall: write 8'h11 then 8'h22 with out_ready = 0 -> level = 2, in_ready = 0, route_0 = 11, route_1 = 22. Hold in_valid with 8'h33 for 3 cycles -> nothing changes. Then read once -> next edge accepts 33 into bank 0.
- Streaming: in_valid = out_ready = 1 continuously with data 1, 2, 3, ... 10 -> after a 1-cycle fill, the selector output matches one word per cycle in order 1..10, sel alternates, level stays 1.
- Wrap/order: random valid and ready, 200 words -> scoreboard reports zero order or data mismatches, level never exceeds 2, and out_valid never rises with level = 0.
- Reset mid-operation: with level = 2, pulse rst_n low -> level = 0, out_valid = 0. The next written word 8'h5A appears on route_0 with sel = 0.
